// File: rtl/jk_master_slave_ff_pkg.sv
// Shared JK command encoding and next-state rule for the master/slave JK flop.
package jk_master_slave_ff_pkg;

  // Indexed as {j, k}.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_cmd_e;

  function automatic logic jk_next(jk_cmd_e cmd, logic q);
    logic next;
    next = q;
    unique case (cmd)
      HOLD:    next = q;
      RST:     next = 1'b0;
      SET:     next = 1'b1;
      TGL:     next = ~q;
      default: next = q;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/jk_master_slave_ff_if.sv
// J/K request and Q/Q_bar result bundle for the master/slave JK flop.
interface jk_master_slave_ff_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;

  modport master (output j, output k, input q, input q_bar);
  modport slave  (input j, input k, output q, output q_bar);
endinterface

// File: rtl/jk_stage.sv
// One-bit JK master/slave pair: master updates on posedge, slave copies on negedge.
module jk_stage
  import jk_master_slave_ff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_m;
  logic r_q;

  // Master evaluates J/K against the slave output, not against itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m <= 1'b0;
    end else begin
      r_m <= jk_next(jk_cmd_e'({i_j, i_k}), r_q);
    end
  end

  always_ff @(negedge clk) begin
    r_q <= r_m;
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_master_slave_ff.sv
// WIDTH independent master/slave JK flops sharing one clock and synchronous reset.
module jk_master_slave_ff #(
  parameter int unsigned WIDTH = 1
) (
  input logic                 clk,
  input logic                 rst,
  jk_master_slave_ff_if.slave jk_bus
);

  logic [WIDTH-1:0] w_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_stage u_stage (
      .clk (clk),
      .rst (rst),
      .i_j (jk_bus.j[g]),
      .i_k (jk_bus.k[g]),
      .o_q (w_q[g])
    );
  end

  assign jk_bus.q     = w_q;
  assign jk_bus.q_bar = ~w_q;

endmodule

// File: tb/tb_jk_master_slave_ff.sv
// Directed and randomized checks of jk_master_slave_ff against a characteristic-equation model.
module tb_jk_master_slave_ff;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [W-1:0] model_m;
  logic [W-1:0] model_q;

  jk_master_slave_ff_if #(.WIDTH(W)) bus ();

  jk_master_slave_ff #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .jk_bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive inputs in the low phase, advance one full cycle, check at the negedge.
  task automatic cycle(input string tag, input logic [W-1:0] j, input logic [W-1:0] k,
                       input logic r);
    bus.j = j;
    bus.k = k;
    rst   = r;
    @(posedge clk);
    // Q+ = J.~Q + ~K.Q ; reset forces 0
    model_m = r ? '0 : ((j & ~model_q) | (~k & model_q));
    #1;
    if (!$isunknown(model_q)) check({tag, "_high_hold"}, bus.q, model_q);
    @(negedge clk);
    model_q = model_m;
    #1;
    check(tag, bus.q, model_q);
    check({tag, "_qbar"}, bus.q_bar, ~model_q);
  endtask

  initial begin
    logic [W-1:0] rj;
    logic [W-1:0] rk;
    logic         rr;
    n_checks = 0;
    n_errors = 0;
    model_q  = 'x;
    model_m  = 'x;
    bus.j    = '0;
    bus.k    = '0;
    rst      = 1'b1;
    @(negedge clk);
    #1;

    // 1: reset two posedges then hold
    cycle("rst0", '0, '0, 1'b1);
    check("rst0_const", bus.q, 4'b0000);
    check("rst0_qbar_const", bus.q_bar, 4'b1111);
    cycle("rst1", '0, '0, 1'b1);
    cycle("hold0", '0, '0, 1'b0);
    cycle("hold1", '0, '0, 1'b0);

    // 2: set then reset
    cycle("set", '1, '0, 1'b0);
    check("set_const", bus.q, 4'b1111);
    cycle("clr", '0, '1, 1'b0);
    check("clr_const", bus.q, 4'b0000);

    // 3: toggle sequence 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      cycle("tgl", '1, '1, 1'b0);
      check("tgl_const", bus.q, (i % 2 == 0) ? 4'b1111 : 4'b0000);
    end

    // 4: low-phase glitch on k must be ignored
    cycle("pre_glitch_set", '1, '0, 1'b0);
    cycle("glitch_hold", '0, '0, 1'b0);
    #1;
    bus.k = '1;
    #5;
    bus.k = '0;
    cycle("post_glitch", '0, '0, 1'b0);
    check("post_glitch_const", bus.q, 4'b1111);

    // 5: reset during toggle, then resume toggling from 0
    cycle("tgl_a", '1, '1, 1'b0);
    cycle("tgl_b", '1, '1, 1'b0);
    cycle("tgl_rst", '1, '1, 1'b1);
    check("tgl_rst_const", bus.q, 4'b0000);
    cycle("tgl_after", '1, '1, 1'b0);
    check("tgl_after_const", bus.q, 4'b1111);

    // 6: mixed per-bit commands
    cycle("w_rst", '0, '0, 1'b1);
    cycle("w_load", 4'b0011, 4'b1100, 1'b0);
    check("w_load_const", bus.q, 4'b0011);
    cycle("w_mix", 4'b1010, 4'b0110, 1'b0);
    check("w_mix_const", bus.q, 4'b1001);
    check("w_mix_qbar_const", bus.q_bar, 4'b0110);

    // Random J/K/rst, with high-phase input changes that must not matter
    for (int i = 0; i < 300; i++) begin
      rj = W'($urandom);
      rk = W'($urandom);
      rr = ($urandom_range(0, 15) == 0);
      bus.j = rj;
      bus.k = rk;
      rst   = rr;
      @(posedge clk);
      model_m = rr ? '0 : ((rj & ~model_q) | (~rk & model_q));
      #2;
      bus.j = W'($urandom);
      bus.k = W'($urandom);
      rst   = $urandom_range(0, 1) == 1;
      check("rnd_high_hold", bus.q, model_q);
      @(negedge clk);
      model_q = model_m;
      #1;
      check("rnd_q", bus.q, model_q);
      check("rnd_qbar", bus.q_bar, ~model_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
